// File: rtl/arm_pkg.sv
// Shared fetch-path constants and the IF/ID pipeline register payload.
package arm_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with its next-PC mux: branch > freeze > sequential.
module pc_register
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned STEP     = arm_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_next_pc;

  // Branch targets are word aligned by clearing the low two bits.
  always_comb begin
    w_next_pc = r_pc + WORD_W'(STEP);
    if (branch_taken) begin
      w_next_pc = branch_addr & ~WORD_W'(3);
    end else if (freeze) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, combinational memory address and the IF/ID register.
// Optional fetch counter enabled by macro FETCH_COUNTER_EN.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = arm_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] instr_mem_addr,
  input  logic [31:0] instr_mem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [WORD_W-1:0] w_pc;
  logic              w_squash;
  logic              w_load;
  if_id_t            r_if_id;

  pc_register #(
    .RESET_PC (RESET_PC),
    .STEP     (PC_STEP)
  ) u_pc (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .pc           (w_pc)
  );

  assign instr_mem_addr = w_pc;
  assign w_squash       = flush | branch_taken;
  assign w_load         = ~w_squash & ~freeze;

  // A taken branch squashes IF/ID even during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (w_squash) begin
      r_if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (w_load) begin
      r_if_id <= '{instr: instr_mem_data, pc: w_pc + WORD_W'(PC_STEP), valid: 1'b1};
    end
  end

  assign if_id_instr = r_if_id.instr;
  assign if_id_pc    = r_if_id.pc;
  assign if_id_valid = r_if_id.valid;

`ifdef FETCH_COUNTER_EN
  logic [WORD_W-1:0] r_fetch_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + WORD_W'(1);
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural pipeline model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] instr_mem_addr;
  logic [31:0] instr_mem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_valid;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .instr_mem_addr (instr_mem_addr),
    .instr_mem_data (instr_mem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign instr_mem_data = mem_word(instr_mem_addr);

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef FETCH_COUNTER_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // Drive one cycle of inputs, let the edge pass, and move the model forward.
  task automatic advance(input logic f, input logic fl, input logic b, input logic [31:0] ba);
    logic [31:0] fetched;
    freeze = f; flush = fl; branch_taken = b; branch_addr = ba;
    fetched = mem_word(m_pc);
    @(posedge clk);
    #1;
    if (fl || b) begin
      m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
    end else if (!f) begin
      m_instr = fetched; m_ipc = m_pc + 32'd4; m_valid = 1'b1;
      m_cnt = m_cnt + cnt_exp(32'd1);
    end
    if (b) m_pc = {ba[31:2], 2'b00};
    else if (!f) m_pc = m_pc + 32'd4;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    checks++; if (instr_mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", instr_mem_addr, 32'h0); end
    checks++; if (if_id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 32'h0); end
    checks++; if (if_id_pc !== 32'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h exp=%h", if_id_pc, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", fetch_count, 32'h0); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      advance(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (instr_mem_addr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr got=%h exp=%h", instr_mem_addr, 32'(4 * i)); end
      checks++; if (if_id_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_ifid_pc got=%h exp=%h", if_id_pc, 32'(4 * i)); end
      checks++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%b exp=1", if_id_valid); end
      checks++; if (if_id_instr !== mem_word(32'(4 * (i - 1)))) begin failures++; $display("FAIL seq_instr got=%h exp=%h", if_id_instr, mem_word(32'(4 * (i - 1)))); end
    end
  endtask

  task automatic test_freeze();
    pulse_reset();
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      advance(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (instr_mem_addr !== 32'h8) begin failures++; $display("FAIL frz_addr got=%h exp=%h", instr_mem_addr, 32'h8); end
      checks++; if (if_id_instr !== mem_word(32'h4) || if_id_pc !== 32'h8) begin failures++; $display("FAIL frz_hold got=%h/%h exp=%h/%h", if_id_instr, if_id_pc, mem_word(32'h4), 32'h8); end
    end
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_mem_addr !== 32'hC) begin failures++; $display("FAIL frz_release_addr got=%h exp=%h", instr_mem_addr, 32'hC); end
    checks++; if (if_id_instr !== mem_word(32'h8)) begin failures++; $display("FAIL frz_release_instr got=%h exp=%h", if_id_instr, mem_word(32'h8)); end
  endtask

  task automatic test_branch();
    pulse_reset();
    for (int i = 0; i < 5; i++) advance(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_mem_addr !== 32'd20) begin failures++; $display("FAIL br_pre_addr got=%h exp=%h", instr_mem_addr, 32'd20); end
    advance(1'b0, 1'b0, 1'b1, 32'h0000_0093);
    checks++; if (instr_mem_addr !== 32'h90) begin failures++; $display("FAIL br_addr got=%h exp=%h", instr_mem_addr, 32'h90); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin failures++; $display("FAIL br_squash got=%b/%h/%h exp=0/0/0", if_id_valid, if_id_instr, if_id_pc); end
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h90) || if_id_pc !== 32'h94) begin failures++; $display("FAIL br_target got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instr, if_id_pc, mem_word(32'h90), 32'h94); end
  endtask

  task automatic test_freeze_branch_flush();
    advance(1'b1, 1'b0, 1'b1, 32'h40);
    checks++; if (instr_mem_addr !== 32'h40) begin failures++; $display("FAIL frzbr_addr got=%h exp=%h", instr_mem_addr, 32'h40); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL frzbr_valid got=%b exp=0", if_id_valid); end
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    advance(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (instr_mem_addr !== 32'h48) begin failures++; $display("FAIL flush_addr got=%h exp=%h", instr_mem_addr, 32'h48); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin failures++; $display("FAIL flush_squash got=%b/%h exp=0/0", if_id_valid, if_id_instr); end
  endtask

  task automatic test_wrap();
    advance(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checks++; if (instr_mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", instr_mem_addr, 32'hFFFF_FFFC); end
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (instr_mem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", instr_mem_addr, 32'h0); end
    checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_ifid got=%h/%b exp=0/1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_counter();
    advance(1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_mem_addr !== 32'h0 || fetch_count !== 32'h0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL async_rst got=%h/%h/%b exp=0/0/0", instr_mem_addr, fetch_count, if_id_valid); end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) advance(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (fetch_count !== cnt_exp(32'd5)) begin failures++; $display("FAIL count5 got=%h exp=%h", fetch_count, cnt_exp(32'd5)); end
    checks++; if (if_id_pc !== 32'd20) begin failures++; $display("FAIL post_rst_pc got=%h exp=%h", if_id_pc, 32'd20); end
  endtask

  task automatic test_random();
    logic f, fl, b;
    for (int i = 0; i < 400; i++) begin
      f  = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 9) == 0);
      advance(f, fl, b, $urandom);
      checks++;
      if (instr_mem_addr !== m_pc || if_id_instr !== m_instr || if_id_pc !== m_ipc ||
          if_id_valid !== m_valid || fetch_count !== m_cnt) begin
        failures++;
        $display("FAIL rand_%0d got=%h/%h/%h/%b/%h exp=%h/%h/%h/%b/%h", i, instr_mem_addr,
                 if_id_instr, if_id_pc, if_id_valid, fetch_count, m_pc, m_instr, m_ipc, m_valid, m_cnt);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1;
    freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    #3;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch();
    test_freeze_branch_flush();
    test_wrap();
    test_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 4, meaning the byte increment per sequential fetch.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port freeze  input  1  hazard stall; holds the PC and the IF/ID register.
REQ-007 SHALL have port flush  input  1  squashes the IF/ID contents on the next edge.
REQ-008 SHALL have port branch_taken  input  1  redirects the PC to branch_addr.
REQ-009 SHALL have port branch_addr  input  32  branch target byte address from EX.
REQ-010 SHALL have port instr_mem_addr  output  32  byte address driven to the combinational instruction memory.
REQ-011 SHALL have port instr_mem_data  input  32  instruction word returned in the same cycle.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction to the decode stage.
REQ-013 SHALL have port if_id_pc  output  32  registered PC+PC_STEP of that instruction.
REQ-014 SHALL have port if_id_valid  output  1  high when if_id_instr is a real fetched instruction.
REQ-015 SHALL have port fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-016 SHALL drive instr_mem_addr = pc combinationally, with no added latency.
REQ-017 SHALL compute next PC with priority branch_taken > freeze > sequential: branch_addr with bits[1:0] forced to 0 / hold / pc+PC_STEP.
REQ-018 SHALL wrap the sequential PC modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0).
REQ-019 SHALL update IF/ID with priority (flush | branch_taken) > freeze > load.
REQ-020 On flush or branch_taken, SHALL set if_id_instr=0, if_id_pc=0 and if_id_valid=0 on the next edge.
REQ-021 On freeze without flush or branch, SHALL hold if_id_instr, if_id_pc and if_id_valid unchanged.
REQ-022 On load, SHALL capture instr_mem_data, pc+PC_STEP and if_id_valid=1.
REQ-023 SHALL give a one-cycle fetch-to-decode latency: the instruction at address A appears on if_id_instr on the edge after instr_mem_addr=A.
REQ-024 When freeze and branch_taken are both high, SHALL take the branch and squash IF/ID, because the control hazard overrides the stall.

Reset
REQ-025 While rst=1, SHALL set pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0 and fetch_count=0 asynchronously.
REQ-026 After rst deasserts mid-program, SHALL issue its first fetch from RESET_PC on the next cycle, with no stale IF/ID content surviving.

Configuration
REQ-027 With macro FETCH_COUNTER_EN defined, fetch_count SHALL increment by 1 (wrapping) on each edge where IF/ID loads (REQ-022).
REQ-028 Without FETCH_COUNTER_EN, fetch_count SHALL be tied to 0, the port SHALL remain present and no counter flops SHALL be inferred.

Structure
REQ-029 Shared package arm_pkg SHALL hold WORD_W=32, PC_STEP=4 and NOP_INSTR=32'h0000_0000.
REQ-030 The PC register with its next-PC mux SHALL be a sub-module pc_register; the IF/ID register SHALL stay in fetch_stage.

Verification
REQ-031 Reset, then 3 free-running cycles -> instr_mem_addr sequence 0, 4, 8, 12; if_id_pc 4, 8, 12; if_id_valid=1 from the first edge.
REQ-032 freeze=1 for 2 cycles at pc=8 -> instr_mem_addr stays 8 and IF/ID holds its word; on release, addr=12 next.
REQ-033 branch_taken=1 with branch_addr=32'h0000_0093 at pc=20 -> next addr 32'h90, if_id_valid=0 for one cycle, then the word at 0x90 is loaded.
REQ-034 freeze=1 together with branch_taken=1, branch_addr=0x40 -> pc=0x40 and IF/ID squashed; flush=1 alone -> IF/ID squashed while the PC still advances.
REQ-035 Force pc=32'hFFFF_FFFC via branch, no further branch -> next addr 0.
REQ-036 Assert rst mid-run with FETCH_COUNTER_EN -> pc=RESET_PC and fetch_count=0 immediately; after 5 loads fetch_count=5; without the macro fetch_count stays 0.
